// File: rtl/cpu_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: loader states, data-port
// control encodings and default bus geometry matching the CPU.
package cpu_mem_responder_pkg;

  localparam int WIDTH_DEFAULT    = 32;
  localparam int ADDRSIZE_DEFAULT = 12;

  typedef enum logic {
    LD_S_LOAD = 1'b0,
    LD_S_RUN  = 1'b1
  } ld_state_t;

  localparam logic MEM_CTRL_READ  = 1'b0;
  localparam logic MEM_CTRL_WRITE = 1'b1;

  // Saturating beat-counter step; the ceiling is passed in so the helper stays
  // independent of the instantiating module's address width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] ceiling);
    if (value >= ceiling) begin
      return ceiling;
    end
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_mem_responder_array.sv
// One-write / one-read RAM with combinational read, used for both the
// instruction and data memories. Contents are never cleared by reset.
module cpu_mem_array
  import cpu_mem_responder_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int ADDRSIZE = ADDRSIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [0:WIDTH-1]    wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [0:WIDTH-1]    rdata
);

  localparam int DEPTH = 1 << ADDRSIZE;

  logic [0:WIDTH-1] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-during-write returns the old word until the next edge lands.
  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: data RAM, instruction RAM and the
// program loader that holds the CPU in reset until the final beat arrives.
module cpu_mem_responder
  import cpu_mem_responder_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int ADDRSIZE = ADDRSIZE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRSIZE-1:0] MEM_ADDR,
  input  logic [0:WIDTH-1]    MEM_OUT,
  input  logic                MEM_CTRL,
  output logic [0:WIDTH-1]    MEM_IN,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [0:WIDTH-1]    INS_MEM,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDRSIZE-1:0] ld_addr,
  input  logic [0:WIDTH-1]    ld_data,
  input  logic                ld_last,
  output logic                cpu_rst,
  output logic [ADDRSIZE:0]   ld_count,
  output logic                ld_err
);

  localparam logic [31:0] LD_COUNT_MAX = 32'(1) << ADDRSIZE;

  ld_state_t         state_reg, state_next;
  logic [ADDRSIZE:0] ld_count_reg, ld_count_next;
  logic              ld_err_reg, ld_err_next;
  logic              cpu_rst_reg, ld_ready_reg;
  logic              imem_we, dmem_we;
  logic              beat_accept;
  logic [31:0]       count_inc;

  assign beat_accept = ld_valid & ld_ready_reg;
  assign count_inc   = sat_inc(32'(ld_count_reg), LD_COUNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LD_S_LOAD;
      ld_count_reg <= '0;
      ld_err_reg   <= 1'b0;
      cpu_rst_reg  <= 1'b1;
      ld_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      ld_count_reg <= ld_count_next;
      ld_err_reg   <= ld_err_next;
      // Outputs decode the upcoming state so they change on the same edge.
      cpu_rst_reg  <= (state_next == LD_S_LOAD);
      ld_ready_reg <= (state_next == LD_S_LOAD);
    end
  end

  always_comb begin
    state_next    = state_reg;
    ld_count_next = ld_count_reg;
    ld_err_next   = ld_err_reg;
    imem_we       = 1'b0;
    dmem_we       = 1'b0;

    case (state_reg)
      LD_S_LOAD: begin
        if (beat_accept) begin
          imem_we       = 1'b1;
          ld_count_next = count_inc[ADDRSIZE:0];
          if (ld_last) begin
            state_next = LD_S_RUN;
          end
        end
      end
      LD_S_RUN: begin
        if (ld_valid) begin
          ld_err_next = 1'b1;
        end
        if (MEM_CTRL == MEM_CTRL_WRITE) begin
          dmem_we = 1'b1;
        end
      end
      default: begin
        state_next = LD_S_LOAD;
      end
    endcase

    // Reset overrides any write that happens to coincide with it.
    if (rst) begin
      imem_we = 1'b0;
      dmem_we = 1'b0;
    end
  end

  cpu_mem_array #(
    .WIDTH    (WIDTH),
    .ADDRSIZE (ADDRSIZE)
  ) imem (
    .clk   (clk),
    .we    (imem_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (INS_ADDR),
    .rdata (INS_MEM)
  );

  cpu_mem_array #(
    .WIDTH    (WIDTH),
    .ADDRSIZE (ADDRSIZE)
  ) dmem (
    .clk   (clk),
    .we    (dmem_we),
    .waddr (MEM_ADDR),
    .wdata (MEM_OUT),
    .raddr (MEM_ADDR),
    .rdata (MEM_IN)
  );

  assign cpu_rst  = cpu_rst_reg;
  assign ld_ready = ld_ready_reg;
  assign ld_count = ld_count_reg;
  assign ld_err   = ld_err_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed plus randomized bench for cpu_mem_responder, checked against a
// transaction-level model of the loader and both memories.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] MEM_ADDR = '0;
  logic [0:31] MEM_OUT = '0;
  logic        MEM_CTRL = 1'b0;
  logic [0:31] MEM_IN;
  logic [11:0] INS_ADDR = '0;
  logic [0:31] INS_MEM;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [11:0] ld_addr = '0;
  logic [0:31] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        cpu_rst;
  logic [12:0] ld_count;
  logic        ld_err;

  cpu_mem_responder dut (
    .clk(clk), .rst(rst),
    .MEM_ADDR(MEM_ADDR), .MEM_OUT(MEM_OUT), .MEM_CTRL(MEM_CTRL), .MEM_IN(MEM_IN),
    .INS_ADDR(INS_ADDR), .INS_MEM(INS_MEM),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .cpu_rst(cpu_rst), .ld_count(ld_count), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: loader phase, counters and the words known in each memory.
  bit          running = 0;
  int          count = 0;
  bit          err = 0;
  logic [31:0] imem_m [int];
  logic [31:0] dmem_m [int];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the model's view of the current inputs, then advance one clock.
  task automatic cycle();
    if (rst) begin
      running = 0; count = 0; err = 0;
    end else if (!running) begin
      if (ld_valid) begin
        imem_m[int'(ld_addr)] = ld_data;
        count = (count < 4096) ? count + 1 : 4096;
        if (ld_last) running = 1;
      end
    end else begin
      if (ld_valid) err = 1;
      if (MEM_CTRL) dmem_m[int'(MEM_ADDR)] = MEM_OUT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_valid = 0; ld_last = 0; MEM_CTRL = 0;
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(!running));
    chk({tag, ".ld_ready"}, 64'(ld_ready), 64'(!running));
    chk({tag, ".ld_count"}, 64'(ld_count), 64'(count));
    chk({tag, ".ld_err"}, 64'(ld_err), 64'(err));
  endtask

  task automatic beat(input logic [11:0] a, input logic [31:0] d, input bit last);
    ld_valid = 1; ld_addr = a; ld_data = d; ld_last = last;
    cycle();
    idle();
  endtask

  task automatic check_imem(input string tag);
    foreach (imem_m[k]) begin
      INS_ADDR = 12'(k);
      #1;
      chk(tag, 64'(INS_MEM), 64'(imem_m[k]));
    end
  endtask

  task automatic dmem_write(input logic [11:0] a, input logic [31:0] d);
    MEM_ADDR = a; MEM_OUT = d; MEM_CTRL = 1;
    cycle();
    MEM_CTRL = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    int nbeats;
    logic [11:0] a;
    logic [31:0] d;

    // Reset state
    do_reset();
    check_ctrl("reset");

    // Directed program load with a stall and an unqualified ld_last
    beat(12'd0, 32'h2000_5001, 0);
    check_ctrl("beat1");
    cycle();
    ld_last = 1;
    cycle();
    ld_last = 0;
    check_ctrl("last_no_valid");
    beat(12'd1, 32'h4001_0001, 0);
    check_ctrl("beat2");
    beat(12'd2, 32'h9000_0000, 1);
    check_ctrl("beat3");
    chk("beat3.count3", 64'(ld_count), 64'd3);
    chk("beat3.cpu_rst_low", 64'(cpu_rst), 64'd0);
    INS_ADDR = 12'd1;
    #1;
    chk("ins_at_1", 64'(INS_MEM), 64'h4001_0001);
    check_imem("imem_directed");

    // Read-during-write on the data port
    dmem_write(12'h010, 32'h1111_1111);
    MEM_ADDR = 12'h010; MEM_OUT = 32'hDEAD_BEEF; MEM_CTRL = 1;
    #1;
    chk("rdw_old", 64'(MEM_IN), 64'h1111_1111);
    cycle();
    MEM_CTRL = 0;
    #1;
    chk("rdw_new", 64'(MEM_IN), 64'hDEAD_BEEF);

    // Randomized data-port traffic in RUN
    for (int i = 0; i < 40; i++) begin
      MEM_ADDR = 12'($urandom_range(0, 15));
      MEM_OUT = $urandom;
      MEM_CTRL = 1'($urandom_range(0, 1));
      #1;
      if (dmem_m.exists(int'(MEM_ADDR)))
        chk("dmem_rand_pre", 64'(MEM_IN), 64'(dmem_m[int'(MEM_ADDR)]));
      cycle();
      MEM_CTRL = 0;
      #1;
      if (dmem_m.exists(int'(MEM_ADDR)))
        chk("dmem_rand_post", 64'(MEM_IN), 64'(dmem_m[int'(MEM_ADDR)]));
    end
    check_ctrl("run_rand");

    // Loader activity while running is flagged and ignored
    dmem_write(12'h020, 32'hCAFE_F00D);
    ld_valid = 1; ld_addr = 12'd0; ld_data = 32'd0;
    cycle();
    idle();
    check_ctrl("run_ld_valid");
    cycle();
    check_ctrl("err_sticky");
    INS_ADDR = 12'd0;
    #1;
    chk("imem0_unchanged", 64'(INS_MEM), 64'h2000_5001);

    // Reset clears the error and re-holds the CPU; data writes in LOAD dropped
    do_reset();
    check_ctrl("rst_after_err");
    dmem_write(12'h020, 32'h1234_5678);
    check_ctrl("load_dwrite");

    // Randomized load with stalls and repeated addresses
    nbeats = 6 + int'($urandom_range(0, 6));
    for (int i = 0; i < nbeats; i++) begin
      if ($urandom_range(0, 1) == 1) cycle();
      a = 12'($urandom_range(0, 15));
      d = $urandom;
      beat(a, d, i == nbeats - 1);
      check_ctrl("rand_beat");
    end
    MEM_ADDR = 12'h020;
    #1;
    chk("dmem_020_kept", 64'(MEM_IN), 64'hCAFE_F00D);
    check_imem("imem_rand");

    // Reset coinciding with an accepted final beat
    do_reset();
    beat(12'd5, 32'h5555_AAAA, 0);
    rst = 1; ld_valid = 1; ld_addr = 12'h7FF; ld_data = 32'h0BAD_0BAD; ld_last = 1;
    cycle();
    rst = 0;
    idle();
    check_ctrl("rst_vs_last");
    cycle();
    check_ctrl("rst_vs_last_hold");
    chk("rst_vs_last.cpu_rst", 64'(cpu_rst), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
